ap_add_seq: RTL and testbench

- Sequencer for bit-serial in-place addition B = A + B across all rows of the associative cell array.
- Drives per-column Key/Mask/Pass compare-write cycles, four truth-table passes per bit position, with a leading carry-column clear.
- Sits between the instruction decoder (start/done handshake) and the cell column muxes (col_a/col_b/col_c select which array columns see Key/Mask/write).
- The final carry-out is left in the carry column.

---
 rtl/ap_add_seq.sv | 212 +++++++++++++++++++++
 tb/tb_ap_add_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_add_seq.sv
// Bit-serial B = A + B sequencer for the associative cell array.
// Issues a carry-column clear, then four compare/write truth-table passes per bit.
module ap_add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned COL_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstIn,
  input  logic             start,
  input  logic [CNT_W-1:0] n_bits,
  input  logic [COL_W-1:0] a_base,
  input  logic [COL_W-1:0] b_base,
  input  logic [COL_W-1:0] c_col,
  input  logic             tag_any,
  output logic [COL_W-1:0] col_a,
  output logic [COL_W-1:0] col_b,
  output logic [COL_W-1:0] col_c,
  output logic [2:0]       key,
  output logic [2:0]       mask,
  output logic [2:0]       pass,
  output logic             cmp_en,
  output logic             wr_en,
  output logic [1:0]       wr_mask,
  output logic [1:0]       wr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_CMP = 3'd1,
    CLR_WR  = 3'd2,
    P_CMP   = 3'd3,
    P_WR    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] bit_q, bit_n;
  logic [1:0]       pidx_q, pidx_n;
  logic [CNT_W-1:0] n_q, n_n;
  logic [COL_W-1:0] a_q, a_n, b_q, b_n, c_q, c_n;

  logic [COL_W-1:0] col_a_n, col_b_n, col_c_n;
  logic [2:0]       key_n, mask_n, pass_n;
  logic             cmp_en_n, wr_en_n, busy_n, done_n;
  logic [1:0]       wr_mask_n, wr_data_n;
  logic             do_adv;

  // Truth table: {C,B,A} compare key and {C,B} written value per pass
  function automatic logic [2:0] pass_key(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b011;
      2'd1:    return 3'b001;
      2'd2:    return 3'b100;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [1:0] pass_data(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b10;
      2'd1:    return 2'b01;
      2'd2:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Next state and next registered outputs
  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    pidx_n  = pidx_q;
    n_n     = n_q;
    a_n     = a_q;
    b_n     = b_q;
    c_n     = c_q;
    do_adv  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_n     = (n_bits > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : n_bits;
          a_n     = a_base;
          b_n     = b_base;
          c_n     = c_col;
          bit_n   = '0;
          pidx_n  = '0;
          state_n = CLR_CMP;
        end
      end
      CLR_CMP: state_n = CLR_WR;
      CLR_WR: begin
        bit_n   = '0;
        pidx_n  = '0;
        state_n = (n_q == '0) ? DONE : P_CMP;
      end
      P_CMP: begin
        if (tag_any) state_n = P_WR;
        else         do_adv  = 1'b1;
      end
      P_WR:    do_adv  = 1'b1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Step to the next pass, next bit, or finish
    if (do_adv) begin
      if (pidx_q == 2'd3) begin
        if ((bit_q + CNT_W'(1)) == n_q) begin
          state_n = DONE;
        end else begin
          bit_n   = bit_q + CNT_W'(1);
          pidx_n  = '0;
          state_n = P_CMP;
        end
      end else begin
        pidx_n  = pidx_q + 2'd1;
        state_n = P_CMP;
      end
    end

    col_a_n   = '0;
    col_b_n   = '0;
    col_c_n   = '0;
    key_n     = '0;
    mask_n    = '0;
    pass_n    = '0;
    cmp_en_n  = 1'b0;
    wr_en_n   = 1'b0;
    wr_mask_n = '0;
    wr_data_n = '0;
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);

    if (state_n != IDLE && state_n != DONE) begin
      col_a_n = a_n + COL_W'(bit_n);
      col_b_n = b_n + COL_W'(bit_n);
      col_c_n = c_n;
    end

    case (state_n)
      CLR_CMP: cmp_en_n = 1'b1;
      CLR_WR: begin
        wr_en_n   = 1'b1;
        wr_mask_n = 2'b10;
      end
      P_CMP: begin
        cmp_en_n = 1'b1;
        mask_n   = 3'b111;
        key_n    = pass_key(pidx_n);
        pass_n   = 3'(pidx_n) + 3'd1;
      end
      P_WR: begin
        wr_en_n   = 1'b1;
        wr_mask_n = 2'b11;
        wr_data_n = pass_data(pidx_n);
        mask_n    = 3'b111;
        key_n     = pass_key(pidx_n);
        pass_n    = 3'(pidx_n) + 3'd1;
      end
      default: ;
    endcase
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clk) begin
    if (rstIn) begin
      state_q <= IDLE;
      bit_q   <= '0;
      pidx_q  <= '0;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      col_a   <= '0;
      col_b   <= '0;
      col_c   <= '0;
      key     <= '0;
      mask    <= '0;
      pass    <= '0;
      cmp_en  <= 1'b0;
      wr_en   <= 1'b0;
      wr_mask <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      pidx_q  <= pidx_n;
      n_q     <= n_n;
      a_q     <= a_n;
      b_q     <= b_n;
      c_q     <= c_n;
      col_a   <= col_a_n;
      col_b   <= col_b_n;
      col_c   <= col_c_n;
      key     <= key_n;
      mask    <= mask_n;
      pass    <= pass_n;
      cmp_en  <= cmp_en_n;
      wr_en   <= wr_en_n;
      wr_mask <= wr_mask_n;
      wr_data <= wr_data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_ap_add_seq.sv
// Self-checking bench for ap_add_seq: a small associative-array model answers
// tag_any and applies writes; results are checked against plain integer addition.
module tb_ap_add_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned COL_W = 8;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned NROWS = 8;

  logic             clk = 1'b0;
  logic             rstIn;
  logic             start;
  logic [CNT_W-1:0] n_bits;
  logic [COL_W-1:0] a_base, b_base, c_col;
  logic             tag_any;
  logic [COL_W-1:0] col_a, col_b, col_c;
  logic [2:0]       key, mask, pass;
  logic             cmp_en, wr_en;
  logic [1:0]       wr_mask, wr_data;
  logic             busy, done;

  ap_add_seq #(.WIDTH(WIDTH), .COL_W(COL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstIn(rstIn), .start(start), .n_bits(n_bits),
    .a_base(a_base), .b_base(b_base), .c_col(c_col), .tag_any(tag_any),
    .col_a(col_a), .col_b(col_b), .col_c(col_c), .key(key), .mask(mask),
    .pass(pass), .cmp_en(cmp_en), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int errs = 0;

  // Array model: 256 columns per row, tags captured on compare, writes on wr_en
  logic [255:0]     mem [NROWS];
  logic [NROWS-1:0] tvec, tags;
  logic [31:0]      ld_a [NROWS];
  logic [31:0]      ld_b [NROWS];
  logic [NROWS-1:0] ld_c;
  logic [7:0]       abase, bbase, cbase;
  logic             load_req = 1'b0;
  int               mode = 0;   // 0: array model, 1: tag_any tied 1, 2: tied 0

  always_comb begin
    tvec = '0;
    for (int r = 0; r < NROWS; r++)
      tvec[r] = (({mem[r][col_c], mem[r][col_b], mem[r][col_a]} & mask) == (key & mask));
  end

  assign tag_any = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : |tvec;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < NROWS; r++) begin
        for (int i = 0; i < 32; i++) begin
          mem[r][8'(abase + i)] <= ld_a[r][i];
          mem[r][8'(bbase + i)] <= ld_b[r][i];
        end
        mem[r][cbase] <= ld_c[r];
      end
    end else begin
      if (cmp_en) tags <= tvec;
      if (wr_en)
        for (int r = 0; r < NROWS; r++)
          if (tags[r]) begin
            if (wr_mask[1]) mem[r][col_c] <= wr_data[1];
            if (wr_mask[0]) mem[r][col_b] <= wr_data[0];
          end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write must directly follow a compare and never overlap one
  logic prev_cmp = 1'b0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) check("wr_protocol", 64'({cmp_en, prev_cmp}), 64'(2'b01));
    prev_cmp <= cmp_en;
  end

  function automatic logic [63:0] sig();
    return 64'({busy, done, cmp_en, wr_en, pass, key, mask, wr_mask, wr_data, col_a, col_b, col_c});
  endfunction

  function automatic logic [63:0] mk(input logic bz, input logic dn, input logic ce, input logic we,
                                     input logic [2:0] ps, input logic [2:0] ky, input logic [2:0] mk_,
                                     input logic [1:0] wm, input logic [1:0] wd,
                                     input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] cc);
    return 64'({bz, dn, ce, we, ps, ky, mk_, wm, wd, ca, cb, cc});
  endfunction

  function automatic logic [31:0] rd_b(input int r);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mem[r][8'(bbase + i)];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic rand_rows();
    for (int r = 0; r < NROWS; r++) begin
      ld_a[r] = $urandom;
      ld_b[r] = $urandom;
      ld_c[r] = 1'($urandom);
    end
  endtask

  // Reference: B's low n bits become (A+B) mod 2^n, upper bits untouched, C = carry out
  task automatic check_rows(input int n);
    int          ne;
    logic [31:0] m, eb;
    logic [32:0] s;
    logic        ec;
    ne = (n > 32) ? 32 : n;
    m  = (ne >= 32) ? 32'hffff_ffff : ((32'd1 << ne) - 32'd1);
    for (int r = 0; r < NROWS; r++) begin
      s  = {1'b0, ld_a[r] & m} + {1'b0, ld_b[r] & m};
      eb = (ld_b[r] & ~m) | (s[31:0] & m);
      ec = (ne == 0) ? 1'b0 : s[ne];
      check($sformatf("row%0d_b", r), 64'(rd_b(r)), 64'(eb));
      check($sformatf("row%0d_c", r), 64'(mem[r][cbase]), 64'(ec));
    end
  endtask

  task automatic run_op(input int n, input bit junk, input bit poke, output int lat, output int nwr);
    n_bits = 6'(n);
    a_base = abase;
    b_base = bbase;
    c_col  = cbase;
    start  = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    nwr = int'(wr_en);
    while (done !== 1'b1 && lat < 600) begin
      if (junk && lat == 4) begin
        start  = 1'b1;
        n_bits = 6'd1;
        a_base = ~abase;
        b_base = 8'd3;
        c_col  = 8'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      nwr += int'(wr_en);
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    if (poke) begin
      start  = 1'b1;
      n_bits = 6'd2;
    end
    tick();
    start = 1'b0;
    check("idle_after_done", sig(), 64'd0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_b;
    logic        exp_c;
  } vec_t;

  vec_t        tv [8];
  logic [2:0]  kt [4];
  logic [1:0]  dt [4];
  int          lat, nwr, ne;
  bit          hit;

  initial begin
    tv[0] = '{4,  32'h9,         32'h9,         32'h2,  1'b1};
    tv[1] = '{4,  32'h5,         32'h3,         32'h8,  1'b0};
    tv[2] = '{1,  32'h1,         32'h1,         32'h0,  1'b1};
    tv[3] = '{8,  32'hff,        32'h1,         32'h0,  1'b1};
    tv[4] = '{0,  32'h7,         32'h5,         32'h5,  1'b0};
    tv[5] = '{37, 32'hffff_ffff, 32'h1,         32'h0,  1'b1};
    tv[6] = '{32, 32'h8000_0000, 32'h8000_0000, 32'h0,  1'b1};
    tv[7] = '{3,  32'hf0,        32'hf5,        32'hf5, 1'b0};
    kt = '{3'b011, 3'b001, 3'b100, 3'b110};
    dt = '{2'b10, 2'b01, 2'b01, 2'b10};

    rstIn = 1'b1; start = 1'b0; n_bits = '0;
    a_base = '0; b_base = '0; c_col = '0;
    tick(); tick();
    check("reset_outputs", sig(), 64'd0);
    rstIn = 1'b0;

    // tag_any tied high: full pass trace with every write issued
    mode = 1;
    n_bits = 6'd4; a_base = 8'd10; b_base = 8'd70; c_col = 8'd140; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_clr_cmp", sig(), mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 8'd10, 8'd70, 8'd140));
    tick();
    check("t1_clr_wr", sig(), mk(1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 8'd10, 8'd70, 8'd140));
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 4; p++) begin
        tick();
        check($sformatf("t1_cmp_b%0d_p%0d", i, p + 1), sig(),
              mk(1, 0, 1, 0, 3'(p + 1), kt[p], 3'b111, 0, 0, 8'(10 + i), 8'(70 + i), 8'd140));
        tick();
        check($sformatf("t1_wr_b%0d_p%0d", i, p + 1), sig(),
              mk(1, 0, 0, 1, 3'(p + 1), kt[p], 3'b111, 2'b11, dt[p], 8'(10 + i), 8'(70 + i), 8'd140));
      end
    tick();
    check("t1_done_T35", sig(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("t1_idle", sig(), 64'd0);

    // tag_any tied low: no pass writes, minimum latency; clamp of oversize n_bits
    mode = 2;
    abase = 8'd0; bbase = 8'd64; cbase = 8'd160;
    run_op(4, 0, 0, lat, nwr);
    check("t0_latency", 64'(lat), 64'd19);
    check("t0_writes", 64'(nwr), 64'd1);
    run_op(WIDTH + 5, 0, 0, lat, nwr);
    check("clamp_latency", 64'(lat), 64'd131);

    // Table vectors through the array model
    mode = 0;
    for (int t = 0; t < 8; t++) begin
      abase = 8'(t * 3); bbase = 8'(t * 3 + 64); cbase = 8'(t * 3 + 160);
      rand_rows();
      ld_a[0] = tv[t].a;
      ld_b[0] = tv[t].b;
      do_load();
      run_op(tv[t].n, 0, (t % 2) == 1, lat, nwr);
      ne = (tv[t].n > 32) ? 32 : tv[t].n;
      check($sformatf("vec%0d_latency", t), 64'((lat >= 3 + 4 * ne) && (lat <= 3 + 8 * ne)), 64'd1);
      check($sformatf("vec%0d_b", t), 64'(rd_b(0)), 64'(tv[t].exp_b));
      check($sformatf("vec%0d_c", t), 64'(mem[0][cbase]), 64'(tv[t].exp_c));
      check_rows(tv[t].n);
    end

    // Random operands, bases (with column wrap) and lengths; start pulsed while busy
    for (int k = 0; k < 6; k++) begin
      abase = 8'($urandom); bbase = abase + 8'd64; cbase = abase + 8'd160;
      rand_rows();
      do_load();
      ne = int'($urandom_range(1, 32));
      run_op(ne, 1, 0, lat, nwr);
      check($sformatf("rnd%0d_latency", k), 64'((lat >= 3 + 4 * ne) && (lat <= 3 + 8 * ne)), 64'd1);
      check_rows(ne);
    end

    // Reset during a pass write, then a clean operation
    mode = 1;
    n_bits = 6'd4; a_base = 8'd5; b_base = 8'd80; c_col = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (wr_en && pass != 3'd0) hit = 1'b1;
    end
    check("rst_found_pwr", 64'(hit), 64'd1);
    rstIn = 1'b1;
    tick();
    rstIn = 1'b0;
    check("rst_mid_outputs", sig(), 64'd0);
    hit = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) hit = 1'b1;
    end
    check("rst_no_done", 64'(hit), 64'd0);
    mode = 0;
    abase = 8'd30; bbase = 8'd94; cbase = 8'd190;
    rand_rows();
    do_load();
    run_op(16, 0, 0, lat, nwr);
    check("post_rst_latency", 64'((lat >= 67) && (lat <= 131)), 64'd1);
    check_rows(16);

    $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
    $finish;
  end

endmodule
